// File: rtl/sdx_pad_arbiter.sv
// sdx_pad_arbiter: time-shares the SDX pad between the I2C slave (open-drain SDA)
// and the OTP serial test/program port.
//
// I2C owns the pad by default. An OTP request is granted only after the bus has
// been idle for IDLE_CYC consecutive cycles. A released-pad turnaround of
// TURN_CYC cycles separates every ownership change. A watchdog forces the pad
// back to I2C if an OTP session stays in OTP for TMO_CYC cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sdx_input         pad input value (asynchronous)
//   sdx_output        pad output data
//   sdx_output_en_n   pad output enable, active low
//   i2c_sda_i         SDA value to the I2C delay block
//   i2c_sda_o         SDA drive from I2C (0 pulls low, 1 releases)
//   otp_req           OTP pad request, level
//   otp_gnt           OTP owns the pad
//   otp_dout, otp_oe  OTP output data / drive enable (active high)
//   otp_din           synchronized pad value to OTP
//   otp_done          one-cycle end-of-session strobe
//   tmo_err           one-cycle pulse on watchdog expiry
//   state_o           current state, for debug (I2C=0, TURN_A=1, OTP=2, TURN_B=3)

module sdx_pad_arbiter #(
    parameter int unsigned IDLE_CYC = 16,
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdx_input,
    output logic       sdx_output,
    output logic       sdx_output_en_n,
    output logic       i2c_sda_i,
    input  logic       i2c_sda_o,
    input  logic       otp_req,
    output logic       otp_gnt,
    input  logic       otp_dout,
    input  logic       otp_oe,
    output logic       otp_din,
    input  logic       otp_done,
    output logic       tmo_err,
    output logic [2:0] state_o
);

    typedef enum logic [1:0] {
        StI2c   = 2'd0,
        StTurnA = 2'd1,
        StOtp   = 2'd2,
        StTurnB = 2'd3
    } state_e;

    localparam logic [7:0] IdleMax  = 8'(IDLE_CYC);
    localparam logic [3:0] TurnLast = 4'(TURN_CYC - 1);
    localparam logic [9:0] TmoLast  = 10'(TMO_CYC - 1);

    state_e     state_q, state_d;
    logic       sync1_q, sdx_s_q;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic [9:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_err_q, tmo_err_d;

    // Synchronizer resets to 1 so an idle (pulled-up) bus is assumed at reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sdx_s_q <= 1'b1;
        end else begin
            sync1_q <= sdx_input;
            sdx_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StI2c;
            idle_cnt_q <= '0;
            turn_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    // Counters default to zero and only advance while the state is held, so
    // every state entry starts them from zero.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        turn_cnt_d = '0;
        tmo_cnt_d  = '0;
        tmo_err_d  = 1'b0;
        unique case (state_q)
            StI2c: begin
                if (sdx_s_q && i2c_sda_o) begin
                    idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + 8'd1;
                end
                if (otp_req && (idle_cnt_q == IdleMax)) begin
                    state_d = StTurnA;
                end
            end
            StTurnA: begin
                if (!otp_req) begin
                    state_d = StTurnB;
                end else if (turn_cnt_q == TurnLast) begin
                    state_d = StOtp;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            StOtp: begin
                // done beats a dropped request, which beats the watchdog
                if (otp_done || !otp_req) begin
                    state_d = StTurnB;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d   = StTurnB;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 10'd1;
                end
            end
            StTurnB: begin
                if (turn_cnt_q == TurnLast) begin
                    state_d = StI2c;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: state_d = StI2c;
        endcase
    end

    // Pad mux decoded from the registered state; turnaround states release the pad.
    always_comb begin
        sdx_output      = 1'b0;
        sdx_output_en_n = 1'b1;
        i2c_sda_i       = 1'b1;
        unique case (state_q)
            StI2c: begin
                sdx_output_en_n = i2c_sda_o;
                i2c_sda_i       = sdx_input;  // raw; the I2C block deglitches it
            end
            StOtp: begin
                sdx_output      = otp_dout;
                sdx_output_en_n = ~otp_oe;
            end
            default: ;
        endcase
    end

    assign otp_gnt = (state_q == StOtp);
    assign otp_din = sdx_s_q;
    assign tmo_err = tmo_err_q;
    assign state_o = {1'b0, state_q};

endmodule

// File: tb/tb_sdx_pad_arbiter.sv
// Bench for sdx_pad_arbiter (IDLE_CYC=16, TURN_CYC=2, TMO_CYC=8).
// Outputs are compared as one vector:
//   {state_o[2:0], otp_gnt, tmo_err, sdx_output, sdx_output_en_n, i2c_sda_i, otp_din}
// Inputs in each record are packed as:
//   {rst, sdx_input, i2c_sda_o, otp_req, otp_dout, otp_oe, otp_done}

module tb_sdx_pad_arbiter;

    localparam int unsigned IdleCyc = 16;
    localparam int unsigned TurnCyc = 2;
    localparam int unsigned TmoCyc  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdx_input;
    logic       sdx_output;
    logic       sdx_output_en_n;
    logic       i2c_sda_i;
    logic       i2c_sda_o;
    logic       otp_req;
    logic       otp_gnt;
    logic       otp_dout;
    logic       otp_oe;
    logic       otp_din;
    logic       otp_done;
    logic       tmo_err;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    sdx_pad_arbiter #(
        .IDLE_CYC(IdleCyc),
        .TURN_CYC(TurnCyc),
        .TMO_CYC (TmoCyc)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sdx_input      (sdx_input),
        .sdx_output     (sdx_output),
        .sdx_output_en_n(sdx_output_en_n),
        .i2c_sda_i      (i2c_sda_i),
        .i2c_sda_o      (i2c_sda_o),
        .otp_req        (otp_req),
        .otp_gnt        (otp_gnt),
        .otp_dout       (otp_dout),
        .otp_oe         (otp_oe),
        .otp_din        (otp_din),
        .otp_done       (otp_done),
        .tmo_err        (tmo_err),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  in;
        int unsigned ncyc;  // rising edges before the check; 0 = combinational only
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [6:0] in, input int unsigned ncyc,
                       input logic [8:0] exp);
        vec_t v;
        v.name = name;
        v.in   = in;
        v.ncyc = ncyc;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [6:0] in);
        {rst, sdx_input, i2c_sda_o, otp_req, otp_dout, otp_oe, otp_done} = in;
    endtask

    function automatic logic [8:0] sample();
        return {state_o, otp_gnt, tmo_err, sdx_output, sdx_output_en_n, i2c_sda_i, otp_din};
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d gnt=%b err=%b out=%b en_n=%b sda_i=%b din=%b, want st=%0d gnt=%b err=%b out=%b en_n=%b sda_i=%b din=%b",
                     name, act[8:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //  name                 rst_sdx_sda_req_dout_oe_done  ncyc  st_gnt_err_out_enn_sdai_din
        add("reset",             7'b1_0_1_0_0_0_0,  2, 9'b000_0_0_0_1_0_1);
        add("i2c_pull_low",      7'b0_0_0_0_0_0_0,  0, 9'b000_0_0_0_0_0_1);
        add("sync_fall_1",       7'b0_0_1_0_0_0_0,  1, 9'b000_0_0_0_1_0_1);
        add("sync_fall_2",       7'b0_0_1_0_0_0_0,  1, 9'b000_0_0_0_1_0_0);
        add("sync_rise_1",       7'b0_1_1_0_0_0_0,  1, 9'b000_0_0_0_1_1_0);
        add("sync_rise_2",       7'b0_1_1_0_0_0_0,  1, 9'b000_0_0_0_1_1_1);
        add("idle_no_req",       7'b0_1_1_0_0_0_0, 20, 9'b000_0_0_0_1_1_1);
        add("req_turn_a",        7'b0_1_1_1_0_0_0,  1, 9'b001_0_0_0_1_1_1);
        add("turn_a_released",   7'b0_0_0_1_0_0_0,  0, 9'b001_0_0_0_1_1_1);
        add("turn_a_hold",       7'b0_1_1_1_0_0_0,  1, 9'b001_0_0_0_1_1_1);
        add("grant",             7'b0_1_1_1_0_0_0,  1, 9'b010_1_0_0_1_1_1);
        add("otp_drive_0",       7'b0_1_1_1_0_1_0,  0, 9'b010_1_0_0_0_1_1);
        add("otp_drive_1",       7'b0_1_1_1_1_1_0,  0, 9'b010_1_0_1_0_1_1);
        add("done_turn_b",       7'b0_1_1_1_0_0_1,  1, 9'b011_0_0_0_1_1_1);
        add("turn_b_hold",       7'b0_1_1_1_0_0_0,  1, 9'b011_0_0_0_1_1_1);
        add("done_back_i2c",     7'b0_1_1_1_0_0_0,  1, 9'b000_0_0_0_1_1_1);
        add("i2c_sda_follows",   7'b0_0_1_1_0_0_0,  0, 9'b000_0_0_0_1_0_1);
        add("no_back_to_back",   7'b0_1_1_1_0_0_0, 16, 9'b000_0_0_0_1_1_1);
        add("regrant_turn_a",    7'b0_1_1_1_0_0_0,  1, 9'b001_0_0_0_1_1_1);
        add("req_drop_turn_a",   7'b0_1_1_0_0_0_0,  1, 9'b011_0_0_0_1_1_1);
        add("turn_b_full",       7'b0_1_1_1_0_0_0,  1, 9'b011_0_0_0_1_1_1);
        add("turn_b_exit",       7'b0_1_1_1_0_0_0,  1, 9'b000_0_0_0_1_1_1);
        add("pend_low_1",        7'b0_1_0_1_0_0_0,  1, 9'b000_0_0_0_0_1_1);
        add("pend_high_1",       7'b0_1_1_1_0_0_0,  9, 9'b000_0_0_0_1_1_1);
        add("pend_low_2",        7'b0_1_0_1_0_0_0,  1, 9'b000_0_0_0_0_1_1);
        add("pend_window",       7'b0_1_1_1_0_0_0, 16, 9'b000_0_0_0_1_1_1);
        add("pend_turn_a",       7'b0_1_1_1_0_0_0,  1, 9'b001_0_0_0_1_1_1);
        add("pend_grant",        7'b0_1_1_1_0_0_0,  2, 9'b010_1_0_0_1_1_1);
        add("wd_hold",           7'b0_1_1_1_0_0_0,  7, 9'b010_1_0_0_1_1_1);
        add("wd_expire",         7'b0_1_1_1_0_0_0,  1, 9'b011_0_1_0_1_1_1);
        add("wd_pulse_end",      7'b0_1_1_1_0_0_0,  1, 9'b011_0_0_0_1_1_1);
        add("wd_back_i2c",       7'b0_1_1_1_0_0_0,  1, 9'b000_0_0_0_1_1_1);
        add("wd_no_regrant",     7'b0_1_1_1_0_0_0, 16, 9'b000_0_0_0_1_1_1);
        add("wd_regrant_a",      7'b0_1_1_1_0_0_0,  1, 9'b001_0_0_0_1_1_1);
        add("wd_regrant",        7'b0_1_1_1_0_0_0,  2, 9'b010_1_0_0_1_1_1);
        add("sim_hold",          7'b0_1_1_1_0_0_0,  7, 9'b010_1_0_0_1_1_1);
        add("sim_done_wins",     7'b0_1_1_1_0_0_1,  1, 9'b011_0_0_0_1_1_1);
        add("sim_back_i2c",      7'b0_1_1_1_0_0_0,  2, 9'b000_0_0_0_1_1_1);
        add("drop_window",       7'b0_1_1_1_0_0_0, 16, 9'b000_0_0_0_1_1_1);
        add("drop_turn_a",       7'b0_1_1_1_0_0_0,  1, 9'b001_0_0_0_1_1_1);
        add("drop_grant",        7'b0_1_1_1_0_0_0,  2, 9'b010_1_0_0_1_1_1);
        add("req_drop_otp",      7'b0_1_1_0_0_0_0,  1, 9'b011_0_0_0_1_1_1);
        add("drop_back_i2c",     7'b0_1_1_0_0_0_0,  2, 9'b000_0_0_0_1_1_1);

        drive(7'b1_0_1_0_0_0_0);
        foreach (vecs[i]) begin
            drive(vecs[i].in);
            if (vecs[i].ncyc == 0) begin
                #1;
            end else begin
                repeat (vecs[i].ncyc) @(posedge clk);
                @(negedge clk);
            end
            check(vecs[i].name, vecs[i].exp);
        end

        // Asynchronous reset in the middle of an OTP session.
        drive(7'b0_1_1_1_0_0_0);
        repeat (IdleCyc + 1 + TurnCyc) @(posedge clk);
        #1;
        check("rst_pre_otp", 9'b010_1_0_0_1_1_1);
        drive(7'b0_1_0_1_0_0_0);  // I2C would pull low; OTP keeps the pad released
        #1;
        check("rst_otp_sda_low", 9'b010_1_0_0_1_1_1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_otp", 9'b000_0_0_0_0_1_1);
        @(negedge clk);
        drive(7'b0_1_1_1_0_0_0);

        // Asynchronous reset while the watchdog pulse is high.
        repeat (IdleCyc + 1 + TurnCyc) @(posedge clk);
        #1;
        check("rst2_grant", 9'b010_1_0_0_1_1_1);
        repeat (TmoCyc) @(posedge clk);
        #1;
        check("rst2_wd_pulse", 9'b011_0_1_0_1_1_1);
        #2;
        rst = 1'b1;
        #1;
        check("rst2_clears_err", 9'b000_0_0_0_1_1_1);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdx_pad_arbiter.md
# sdx_pad_arbiter

Time-shares the single SDX pad between the I2C slave (open-drain SDA) and the OTP serial test/program port. I2C owns the pad by default. The OTP controller requests the pad and is granted it only after the bus has been idle for a programmable number of cycles. A released-pad turnaround is inserted on every ownership change. A watchdog returns the pad to I2C if an OTP session overruns. The block sits between the SDX pad cell and the I2C delay block / OTP controller.

## Interface

Parameters:
- `IDLE_CYC`, default 16: consecutive idle cycles required before the pad is handed to OTP. Range 1..255.
- `TURN_CYC`, default 2: released-pad turnaround cycles on each ownership change. Range 1..15.
- `TMO_CYC`, default 255: maximum cycles in the OTP state before a forced return. Range 1..1023.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sdx_input` in 1: pad input value, asynchronous.
- `sdx_output` out 1: pad output data.
- `sdx_output_en_n` out 1: pad output enable, active low.
- `i2c_sda_i` out 1: SDA input to the I2C delay block.
- `i2c_sda_o` in 1: SDA drive from I2C. 0 pulls the pad low; 1 releases it.
- `otp_req` in 1: OTP pad request, level-sensitive.
- `otp_gnt` out 1: OTP owns the pad.
- `otp_dout` in 1: OTP output data.
- `otp_oe` in 1: OTP drive enable, active high.
- `otp_din` out 1: synchronized pad value to OTP.
- `otp_done` in 1: one-cycle end-of-session strobe.
- `tmo_err` out 1: one-cycle pulse on watchdog expiry.
- `state_o` out 3: current state encoding, for debug.

## Operation

Synchronizer:
- `sdx_input` passes through a 2-flop synchronizer to form `sdx_s`. Reset value is 1.

States (encoding `state_o`): I2C=0, TURN_A=1, OTP=2, TURN_B=3.

Pad, I2C and OTP outputs per state:
- **I2C**
  - Pad: `sdx_output`=0, `sdx_output_en_n`=`i2c_sda_o`.
  - I2C: `i2c_sda_i`=`sdx_input` (combinational, unsynchronized; the I2C block deglitches it).
- **TURN_A / TURN_B**
  - Pad: `sdx_output`=0, `sdx_output_en_n`=1 (released).
  - I2C: `i2c_sda_i`=1.
- **OTP**
  - Pad: `sdx_output`=`otp_dout`, `sdx_output_en_n`=~`otp_oe`.
  - I2C: `i2c_sda_i`=1.
- `otp_din`=`sdx_s` in every state.
- `otp_gnt`=1 only in OTP, decoded from the registered state.

Idle counter `idle_cnt` (8 bit, saturates at `IDLE_CYC`):
- Counts while in I2C with `sdx_s`=1 and `i2c_sda_o`=1.
- Clears on any cycle where either is low.
- Clears on entry to I2C.

Transitions:
- I2C → TURN_A: `otp_req`=1 and `idle_cnt`==`IDLE_CYC`.
- TURN_A → OTP: after `TURN_CYC` cycles in TURN_A. Turn counter is 4 bit and clears on state entry.
- TURN_A → TURN_B: `otp_req` drops during TURN_A. TURN_B then runs its full `TURN_CYC`.
- OTP → TURN_B, priority order:
  1. `otp_done`=1.
  2. `otp_req`=0.
  3. Watchdog: `tmo_cnt` (10 bit, clears on OTP entry) reaches `TMO_CYC`. `tmo_err` pulses for 1 cycle, registered and concurrent with the transition edge.
- TURN_B → I2C: after `TURN_CYC` cycles in TURN_B.

Boundary conditions:
- `otp_done` and watchdog expiry in the same cycle: done wins; `tmo_err` stays 0.
- `otp_req` held high through TURN_B and I2C: no re-grant until a fresh `IDLE_CYC` idle window completes. No back-to-back grants.
- I2C activity (SDA low) before `idle_cnt` saturates: the request is held pending, with no timeout.
- Reset asserted mid-session: state goes to I2C immediately (asynchronous).
  - `otp_gnt`=0 and `tmo_err`=0 at once.
  - The pad reverts to I2C control with no turnaround.

## Timing

Reset values:
- State I2C; all counters 0.
- `otp_gnt`=0, `tmo_err`=0, `state_o`=0.
- Synchronizer flops 1.
- Combinational outputs follow the I2C mapping.

Latency:
- Bus idle and `otp_req` rising at edge N: TURN_A from edge N+1; OTP and `otp_gnt`=1 from edge N+1+`TURN_CYC`.
- `otp_done` at edge M: TURN_B from M+1; `otp_gnt`=0 from M+1; I2C from M+1+`TURN_CYC`.
- Pad to `otp_din`: 2 cycles.
- Watchdog: OTP is held exactly `TMO_CYC` cycles before the forced return.

## Test plan

- **Idle grant:** reset, SDA idle 16 cycles, `otp_req`=1 at edge N → TURN_A at N+1, `otp_gnt`=1 at N+3, pad released during TURN_A.
- **Pending request:** `otp_req`=1 while `i2c_sda_o` toggles low every 10 cycles → no grant. Stop toggling → grant 16+1+2 cycles after the last low.
- **OTP drive and done:**
  - `otp_oe`=1, `otp_dout`=0 → `sdx_output_en_n`=0, `sdx_output`=0.
  - `otp_done` pulse → `otp_gnt`=0 next cycle, I2C 2 cycles later, `i2c_sda_i` follows `sdx_input`.
- **Watchdog:** `TMO_CYC`=8, hold `otp_req` with no done → exactly 8 cycles in OTP, `tmo_err` 1-cycle pulse, TURN_B. No re-grant without a new 16-cycle idle window.
- **Simultaneous:** `otp_done` on the same cycle as watchdog expiry → TURN_B, `tmo_err`=0.
- **Reset mid-OTP:** assert `rst` asynchronously between edges → immediately `otp_gnt`=0, `state_o`=0, `sdx_output_en_n`=`i2c_sda_o`.
